sha256_msg_sched_ctrl: RTL and testbench

Sequencer for the SHA-256 message schedule. It accepts one 512-bit block as 16 serial 32-bit words, then emits W0..W63 one word per cycle to the compression round engine through a valid/ready handshake. W16..W63 are generated on the fly in a 16-entry circular buffer, replacing the flat 48-output combinational expansion. Sits between the padding/block loader and the round controller.

---
 rtl/sha256_msg_sched_ctrl.sv | 156 +++++++++++++++
 tb/tb_sha256_msg_sched_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched_ctrl.sv
// SHA-256 message schedule sequencer.
// Loads one 512-bit block as 16 serial 32-bit words, then streams W0..W63
// to the round engine over a valid/ready handshake. W16..W63 are produced
// one per advance in a 16-entry circular buffer: the slot holding W[t-16]
// is overwritten with W[t] as W[t] is presented.
module sha256_msg_sched_ctrl #(
   parameter int NUM_ROUNDS = 64
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_w_valid,
   input  logic [31:0] i_w,
   output logic        o_w_ready,
   output logic        o_wt_valid,
   output logic [31:0] o_wt,
   output logic [5:0]  o_t,
   input  logic        i_wt_ready,
   output logic        o_busy,
   output logic        o_done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

   logic [1:0]  state;
   logic [3:0]  load_cnt;
   logic [31:0] slot [16];

   logic        w_hs;
   logic        out_hs;
   logic        last_word;
   logic        advance;
   logic [5:0]  next_t;
   logic [3:0]  idx_t;
   logic [3:0]  idx_m2;
   logic [3:0]  idx_m7;
   logic [3:0]  idx_m15;
   logic [31:0] sig0;
   logic [31:0] sig1;
   logic [31:0] gen_w;
   logic [31:0] next_word;
   logic        buf_we;
   logic [3:0]  buf_waddr;
   logic [31:0] buf_wdata;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   assign o_w_ready = (state == IDLE) || (state == LOAD);
   assign o_busy    = (state != IDLE);

   // Handshake qualifiers and the next schedule word to present.
   always_comb begin
      w_hs      = i_w_valid & o_w_ready;
      out_hs    = o_wt_valid & i_wt_ready;
      last_word = (o_t == LAST_T);
      advance   = (state == RUN) & out_hs & ~last_word & ~i_clr;
      next_t    = o_t + 6'd1;
      // Slot indices for W[t-16], W[t-15], W[t-7], W[t-2] (mod 16).
      idx_t     = next_t[3:0];
      idx_m15   = next_t[3:0] + 4'd1;
      idx_m7    = next_t[3:0] + 4'd9;
      idx_m2    = next_t[3:0] + 4'd14;
      sig0      = rotr(slot[idx_m15], 7) ^ rotr(slot[idx_m15], 18) ^ (slot[idx_m15] >> 3);
      sig1      = rotr(slot[idx_m2], 17) ^ rotr(slot[idx_m2], 19) ^ (slot[idx_m2] >> 10);
      gen_w     = sig1 + slot[idx_m7] + sig0 + slot[idx_t];
      next_word = (next_t[5:4] == 2'd0) ? slot[idx_t] : gen_w;
   end

   // Buffer write port: message words during load, generated words on advance.
   always_comb begin
      buf_we    = 1'b0;
      buf_waddr = load_cnt;
      buf_wdata = i_w;
      if (!i_clr) begin
         if (w_hs) begin
            buf_we = 1'b1;
         end else if (advance && (next_t[5:4] != 2'd0)) begin
            buf_we    = 1'b1;
            buf_waddr = idx_t;
            buf_wdata = gen_w;
         end
      end
   end

   // Circular schedule buffer; contents are don't-care after reset.
   always_ff @(posedge i_clk) begin
      if (buf_we) begin
         slot[buf_waddr] <= buf_wdata;
      end
   end

   // Control FSM and registered output word.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         load_cnt   <= 4'd0;
         o_wt_valid <= 1'b0;
         o_wt       <= 32'd0;
         o_t        <= 6'd0;
         o_done     <= 1'b0;
      end else if (i_clr) begin
         state      <= IDLE;
         load_cnt   <= 4'd0;
         o_wt_valid <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (w_hs) begin
                  load_cnt <= 4'd1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               if (w_hs) begin
                  if (load_cnt == 4'd15) begin
                     load_cnt <= 4'd0;
                     state    <= RUN;
                  end else begin
                     load_cnt <= load_cnt + 4'd1;
                  end
               end
            end
            RUN: begin
               if (!o_wt_valid) begin
                  // First cycle of RUN: present W0 straight from the buffer.
                  o_wt       <= slot[0];
                  o_t        <= 6'd0;
                  o_wt_valid <= 1'b1;
               end else if (out_hs) begin
                  if (last_word) begin
                     o_wt_valid <= 1'b0;
                     o_done     <= 1'b1;
                     state      <= DONE;
                  end else begin
                     o_wt <= next_word;
                     o_t  <= next_t;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_sched_ctrl.sv
// Self-checking bench for sha256_msg_sched_ctrl: a flat 64-word reference
// schedule is compared against every presented word.
module tb_sha256_msg_sched_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_clr;
   logic        i_w_valid;
   logic [31:0] i_w;
   logic        o_w_ready;
   logic        o_wt_valid;
   logic [31:0] o_wt;
   logic [5:0]  o_t;
   logic        i_wt_ready;
   logic        o_busy;
   logic        o_done;

   sha256_msg_sched_ctrl #(.NUM_ROUNDS(64)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr      (i_clr),
      .i_w_valid  (i_w_valid),
      .i_w        (i_w),
      .o_w_ready  (o_w_ready),
      .o_wt_valid (o_wt_valid),
      .o_wt       (o_wt),
      .o_t        (o_t),
      .i_wt_ready (i_wt_ready),
      .o_busy     (o_busy),
      .o_done     (o_done)
   );

   always #5 i_clk = ~i_clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] msg   [16];
   logic [31:0] exp_w [64];
   int          words_total = 0;
   int          dones_total = 0;
   logic [31:0] last_w63 = 32'd0;
   int          exp_t = 0;
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [31:0] prev_wt = 32'd0;
   logic [5:0]  prev_t = 6'd0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   // Textbook expansion over a flat array.
   task automatic compute_model();
      for (int t = 0; t < 64; t++) begin
         if (t < 16) begin
            exp_w[t] = msg[t];
         end else begin
            exp_w[t] = (ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                     + exp_w[t-7]
                     + (ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                     + exp_w[t-16];
         end
      end
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) msg[i] = 32'd0;
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
      compute_model();
   endtask

   // Compare process: every presented word against the model, plus stall stability.
   always @(negedge i_clk) begin
      if (i_rst) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else begin
         if (o_done) dones_total++;
         if (prev_valid && !prev_ready) begin
            check32("stall_valid", {31'd0, o_wt_valid}, 32'd1);
            check32("stall_wt", o_wt, prev_wt);
            check32("stall_t", {26'd0, o_t}, {26'd0, prev_t});
         end
         if (o_wt_valid) begin
            if (!prev_valid) exp_t = 0;
            if (exp_t > 63) begin
               check32("overrun_t", {26'd0, o_t}, 32'd63);
            end else begin
               check32("t", {26'd0, o_t}, exp_t[31:0]);
               check32($sformatf("W%0d", exp_t), o_wt, exp_w[exp_t]);
               if (i_wt_ready) begin
                  words_total++;
                  if (exp_t == 63) last_w63 = o_wt;
                  exp_t++;
               end
            end
         end
         prev_valid = o_wt_valid;
         prev_ready = i_wt_ready;
         prev_wt    = o_wt;
         prev_t     = o_t;
      end
   end

   task automatic load_block(input bit gap);
      bit acc;
      int bound;
      for (int i = 0; i < 16; i++) begin
         i_w_valid = 1'b1;
         i_w       = msg[i];
         bound     = 0;
         do begin
            acc = o_w_ready;
            @(posedge i_clk); #1;
            bound++;
         end while (!acc && bound < 100);
         if (!acc) check32("load_timeout", 32'd0, 32'd1);
         if (i < 15) begin
            check32("load_ready", {31'd0, o_w_ready}, 32'd1);
            check32("load_novalid", {31'd0, o_wt_valid}, 32'd0);
         end else begin
            check32("run_ready", {31'd0, o_w_ready}, 32'd0);
            check32("run_busy", {31'd0, o_busy}, 32'd1);
         end
         i_w_valid = 1'b0;
         if (gap) begin
            @(posedge i_clk); #1;
         end
      end
   endtask

   task automatic run_block(input bit stall);
      int w0;
      int d0;
      bit seen;
      w0   = words_total;
      d0   = dones_total;
      seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         i_wt_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge i_clk); #1;
         if (dones_total > d0) seen = 1'b1;
      end
      if (!seen) check32("done_timeout", 32'd0, 32'd1);
      @(posedge i_clk); #1;
      check32("words", 32'(words_total - w0), 32'd64);
      check32("dones", 32'(dones_total - d0), 32'd1);
      check32("w63", last_w63, exp_w[63]);
      check32("idle_busy", {31'd0, o_busy}, 32'd0);
      check32("idle_valid", {31'd0, o_wt_valid}, 32'd0);
   endtask

   initial begin
      int d0;
      i_rst      = 1'b1;
      i_clr      = 1'b0;
      i_w_valid  = 1'b0;
      i_w        = 32'd0;
      i_wt_ready = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check32("rst_valid", {31'd0, o_wt_valid}, 32'd0);
      check32("rst_wt", o_wt, 32'd0);
      check32("rst_t", {26'd0, o_t}, 32'd0);
      check32("rst_done", {31'd0, o_done}, 32'd0);
      check32("rst_busy", {31'd0, o_busy}, 32'd0);
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      // Model pins from the known "abc" schedule.
      set_abc();
      check32("model_W16", exp_w[16], 32'h61626380);
      check32("model_W17", exp_w[17], 32'h000F0000);
      check32("model_W63", exp_w[63], 32'h12B1EDEB);

      // "abc", back-to-back load, no stalls.
      load_block(1'b0);
      run_block(1'b0);
      check32("abc_W63", last_w63, 32'h12B1EDEB);

      // Random output stalls.
      load_block(1'b0);
      run_block(1'b1);
      check32("stall_W63", last_w63, 32'h12B1EDEB);

      // Gapped load.
      load_block(1'b1);
      run_block(1'b0);

      // Abort at t=30.
      load_block(1'b0);
      i_wt_ready = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(posedge i_clk); #1;
         if (o_wt_valid && o_t == 6'd30) break;
      end
      check32("clr_at_t", {26'd0, o_t}, 32'd30);
      d0    = dones_total;
      i_clr = 1'b1;
      @(posedge i_clk); #1;
      i_clr = 1'b0;
      check32("clr_valid", {31'd0, o_wt_valid}, 32'd0);
      check32("clr_busy", {31'd0, o_busy}, 32'd0);
      check32("clr_done", {31'd0, o_done}, 32'd0);
      repeat (3) @(posedge i_clk);
      #1;
      check32("clr_nodone", 32'(dones_total - d0), 32'd0);
      load_block(1'b0);
      run_block(1'b0);
      check32("clr_W63", last_w63, 32'h12B1EDEB);

      // Reset after 7 loaded words.
      for (int i = 0; i < 7; i++) begin
         i_w_valid = 1'b1;
         i_w       = msg[i];
         @(posedge i_clk); #1;
      end
      i_w_valid = 1'b0;
      check32("pre_rst_busy", {31'd0, o_busy}, 32'd1);
      #2;
      i_rst = 1'b1;
      #1;
      check32("arst_busy", {31'd0, o_busy}, 32'd0);
      check32("arst_wt", o_wt, 32'd0);
      check32("arst_t", {26'd0, o_t}, 32'd0);
      check32("arst_valid", {31'd0, o_wt_valid}, 32'd0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      check32("post_rst_valid", {31'd0, o_wt_valid}, 32'd0);
      load_block(1'b0);
      run_block(1'b0);
      check32("rst_W63", last_w63, 32'h12B1EDEB);

      // Two blocks back-to-back, second all zero.
      load_block(1'b0);
      run_block(1'b0);
      for (int i = 0; i < 16; i++) msg[i] = 32'd0;
      compute_model();
      check32("model_zero_W63", exp_w[63], 32'd0);
      load_block(1'b0);
      run_block(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
